// File: rtl/fourbit_adder_checker.sv
// fourbit_adder_checker: exhaustive {a, b, cin} sweep self-test for a WIDTH-bit adder
module fourbit_adder_checker #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERRW          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic             first_fail_valid,
    output logic [2*WIDTH:0] first_fail_vec
);
    localparam int VW = 2*WIDTH+1;
    localparam int SW = $clog2(SETTLE_CYCLES+1);
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
    state_t          state;
    logic [VW-1:0]   idx;
    logic [SW-1:0]   settle_cnt;
    logic [WIDTH:0]  expected;
    logic            mismatch;
    logic            last;
    assign {dut_a, dut_b, dut_cin} = idx;
    always_comb begin
        expected = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
        mismatch = {dut_cout, dut_sum} != expected;
        last     = &idx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state            <= APPLY;
                    idx              <= '0;
                    settle_cnt       <= '0;
                    busy             <= 1'b1;
                    done             <= 1'b0;
                    pass             <= 1'b0;
                    err_count        <= '0;
                    first_fail_valid <= 1'b0;
                    first_fail_vec   <= '0;
                end
                APPLY: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_cnt == SW'(SETTLE_CYCLES-1)) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (!(&err_count)) err_count <= err_count + ERRW'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= idx;
                        end
                    end
                    // The final vector ends the sweep in place; idx never wraps back to 0
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && !first_fail_valid;
                    end else begin
                        idx   <= idx + VW'(1);
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
